// File: rtl/lcd_pkg.sv
// Shared constants for the LCD bus sequencer: FSM encoding, default timings, counter width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lcd_pkg;

   localparam int CNT_W    = 6;

   // Default interface timings, in core clock cycles
   localparam int T_AS_DEF = 2;
   localparam int T_PW_DEF = 12;
   localparam int T_H_DEF  = 2;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_ENH   = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_FIN   = 3'd4;

   // A phase of t cycles loads t-1, because the counter's zero cycle is the last one
   function automatic logic [CNT_W-1:0] ld_val(input int t);
      return CNT_W'(t - 1);
   endfunction

endpackage

// File: rtl/lcd_timer.sv
// Shared phase down-counter: load a value, count down to zero and stay there.
// Latency: load takes effect on the next edge; zero_o follows the registered count.
// Backpressure: none; load_i always wins over counting.
// Ports: clk/nRst clock and async active-low reset; load_i/load_val_i load request and value;
//        value_o current count; zero_o high when the count is zero.
module lcd_timer
   import lcd_pkg::*;
(
   input  logic             clk,
   input  logic             nRst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic [CNT_W-1:0] value_o,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturates at zero so a phase never wraps if the FSM lingers
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign value_o = cnt_q;
   assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_sequencer.sv
// Host-strobe to HD44780-style LCD bus sequencer (8-bit or 4-bit bus).
// Latency: acceptance edge to DONE is T_AS+T_PW+T_H+1 cycles (2*(T_AS+T_PW+T_H)+1 in nibble mode).
// Backpressure: host strobes are ignored while BUSY; a new request needs nCS to go high first.
// Ports: clk/nRst clock and async active-low reset; nCS/nWR/nRD/RS/DIN host request;
//        DOUT/BUSY/DONE host status; LCD_RS/LCD_RW/LCD_EN/LCD_DB_O/LCD_DB_OE/LCD_DB_I LCD pins.
module lcd_bus_sequencer
   import lcd_pkg::*;
#(
   parameter int T_AS   = T_AS_DEF,
   parameter int T_PW   = T_PW_DEF,
   parameter int T_H    = T_H_DEF,
   parameter int NIBBLE = 0
)(
   input  logic       clk,
   input  logic       nRst,
   input  logic       nCS,
   input  logic       nWR,
   input  logic       nRD,
   input  logic       RS,
   input  logic [7:0] DIN,
   output logic [7:0] DOUT,
   output logic       BUSY,
   output logic       DONE,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_EN,
   output logic [7:0] LCD_DB_O,
   output logic       LCD_DB_OE,
   input  logic [7:0] LCD_DB_I
);

   localparam logic [CNT_W-1:0] LD_AS = ld_val(T_AS);
   localparam logic [CNT_W-1:0] LD_PW = ld_val(T_PW);
   localparam logic [CNT_W-1:0] LD_H  = ld_val(T_H);

   // Control state
   logic [2:0]       state_q, state_d;
   logic             armed_q, armed_d;
   logic             nib_q, nib_d;       // 0 = high-nibble pass, 1 = low-nibble pass
   logic             rs_q, rs_d;
   logic             rw_q, rw_d;
   logic [7:0]       din_q, din_d;
   logic [7:0]       rdbuf_q, rdbuf_d;

   // Pin/status output registers, computed from the control state one cycle behind it
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             en_q, en_d;
   logic             oe_q, oe_d;
   logic             lrs_q, lrs_d;
   logic             lrw_q, lrw_d;
   logic [7:0]       db_q, db_d;
   logic [7:0]       dout_q, dout_d;

   logic             tmr_load;
   logic [CNT_W-1:0] tmr_ld_val;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_zero;
   logic             accept;
   logic             rd_sample;

   lcd_timer u_timer (
      .clk        (clk),
      .nRst       (nRst),
      .load_i     (tmr_load),
      .load_val_i (tmr_ld_val),
      .value_o    (tmr_val),
      .zero_o     (tmr_zero)
   );

   // Exactly one strobe low; both low is treated as a malformed cycle
   assign accept = armed_q & ~nCS & (nWR ^ nRD);

   always_comb begin
      state_d    = state_q;
      armed_d    = armed_q;
      nib_d      = nib_q;
      rs_d       = rs_q;
      rw_d       = rw_q;
      din_d      = din_q;
      tmr_load   = 1'b0;
      tmr_ld_val = '0;
      case (state_q)
         ST_IDLE: begin
            if (nCS) begin
               armed_d = 1'b1;
            end else if (accept) begin
               state_d    = ST_SETUP;
               armed_d    = 1'b0;
               nib_d      = 1'b0;
               rs_d       = RS;
               rw_d       = ~nRD;
               din_d      = DIN;
               tmr_load   = 1'b1;
               tmr_ld_val = LD_AS;
            end
         end
         ST_SETUP: begin
            if (tmr_zero) begin
               state_d    = ST_ENH;
               tmr_load   = 1'b1;
               tmr_ld_val = LD_PW;
            end
         end
         ST_ENH: begin
            if (tmr_zero) begin
               state_d    = ST_HOLD;
               tmr_load   = 1'b1;
               tmr_ld_val = LD_H;
            end
         end
         ST_HOLD: begin
            if (tmr_zero) begin
               if ((NIBBLE != 0) && !nib_q) begin
                  state_d    = ST_SETUP;
                  nib_d      = 1'b1;
                  tmr_load   = 1'b1;
                  tmr_ld_val = LD_AS;
               end else begin
                  state_d = ST_FIN;
               end
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // The pins lag the state by one cycle, so the final cycle of the EN pulse on the pin
   // is the first HOLD state cycle; the read bus is captured at the end of it.
   assign rd_sample = rw_q && (state_q == ST_HOLD) && (tmr_val == LD_H);

   always_comb begin
      rdbuf_d = rdbuf_q;
      if (rd_sample) begin
         if (NIBBLE != 0) begin
            if (nib_q) rdbuf_d[3:0] = LCD_DB_I[7:4];
            else       rdbuf_d[7:4] = LCD_DB_I[7:4];
         end else begin
            rdbuf_d = LCD_DB_I;
         end
      end
   end

   always_comb begin
      busy_d = (state_q == ST_SETUP) || (state_q == ST_ENH) || (state_q == ST_HOLD);
      done_d = (state_q == ST_FIN);
      en_d   = (state_q == ST_ENH);
      oe_d   = busy_d & ~rw_q;
      lrs_d  = rs_q;
      lrw_d  = rw_q;
      db_d   = '0;
      if (oe_d) begin
         if (NIBBLE != 0) db_d = {(nib_q ? din_q[3:0] : din_q[7:4]), 4'h0};
         else             db_d = din_q;
      end
      dout_d = (done_d && rw_q) ? rdbuf_q : dout_q;
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q <= ST_IDLE;
         armed_q <= 1'b1;
         nib_q   <= 1'b0;
         rs_q    <= 1'b0;
         rw_q    <= 1'b0;
         din_q   <= '0;
         rdbuf_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         en_q    <= 1'b0;
         oe_q    <= 1'b0;
         lrs_q   <= 1'b0;
         lrw_q   <= 1'b0;
         db_q    <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         armed_q <= armed_d;
         nib_q   <= nib_d;
         rs_q    <= rs_d;
         rw_q    <= rw_d;
         din_q   <= din_d;
         rdbuf_q <= rdbuf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         en_q    <= en_d;
         oe_q    <= oe_d;
         lrs_q   <= lrs_d;
         lrw_q   <= lrw_d;
         db_q    <= db_d;
         dout_q  <= dout_d;
      end
   end

   assign DOUT      = dout_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign LCD_RS    = lrs_q;
   assign LCD_RW    = lrw_q;
   assign LCD_EN    = en_q;
   assign LCD_DB_O  = db_q;
   assign LCD_DB_OE = oe_q;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Bench for lcd_bus_sequencer: one 8-bit and one 4-bit instance on a shared host bus.
// Latency: n/a.
// Backpressure: n/a.
module tb_lcd_bus_sequencer;

   logic       clk = 1'b0;
   logic       nRst;
   logic       ncs8, ncs4, nwr, nrd, rs;
   logic [7:0] din;
   logic [7:0] lcd_i8, lcd_i4;

   logic [7:0] dout8, dout4, db8, db4;
   logic       busy8, busy4, done8, done4, lrs8, lrs4, lrw8, lrw4, en8, en4, oe8, oe4;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int p4 = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lcd_bus_sequencer #(.T_AS(2), .T_PW(12), .T_H(2), .NIBBLE(0)) dut8 (
      .clk(clk), .nRst(nRst), .nCS(ncs8), .nWR(nwr), .nRD(nrd), .RS(rs), .DIN(din),
      .DOUT(dout8), .BUSY(busy8), .DONE(done8), .LCD_RS(lrs8), .LCD_RW(lrw8), .LCD_EN(en8),
      .LCD_DB_O(db8), .LCD_DB_OE(oe8), .LCD_DB_I(lcd_i8));

   lcd_bus_sequencer #(.T_AS(2), .T_PW(12), .T_H(2), .NIBBLE(1)) dut4 (
      .clk(clk), .nRst(nRst), .nCS(ncs4), .nWR(nwr), .nRD(nrd), .RS(rs), .DIN(din),
      .DOUT(dout4), .BUSY(busy4), .DONE(done4), .LCD_RS(lrs4), .LCD_RW(lrw4), .LCD_EN(en4),
      .LCD_DB_O(db4), .LCD_DB_OE(oe4), .LCD_DB_I(lcd_i4));

   // 4-bit LCD model: first pulse of a read returns nibble 6, second returns 9
   always @(posedge en4 or negedge nRst) begin
      if (!nRst) p4 <= 0;
      else       p4 <= p4 + 1;
   end
   assign lcd_i4 = p4[0] ? 8'h65 : 8'h93;

   logic [1:0] en_w, done_w, busy_w, rs_w, rw_w, oe_w;
   logic [7:0] db_w [2];
   logic [7:0] dout_w [2];
   assign en_w   = {en4, en8};
   assign done_w = {done4, done8};
   assign busy_w = {busy4, busy8};
   assign rs_w   = {lrs4, lrs8};
   assign rw_w   = {lrw4, lrw8};
   assign oe_w   = {oe4, oe8};
   assign db_w[0] = db8;   assign db_w[1] = db4;
   assign dout_w[0] = dout8; assign dout_w[1] = dout4;

   typedef struct {
      int         unit;
      int         acc;
      int         lat;
      int         pulses;
      logic [7:0] db0;
      logic [7:0] db1;
      logic       rs;
      logic       rw;
      logic       oe;
      logic [7:0] dout;
   } exp_t;

   exp_t q[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   int         pulses [2];
   int         en_tot [2];
   int         unstable [2];
   logic [7:0] cap0 [2];
   logic [7:0] cap1 [2];
   logic       rs_c [2], rw_c [2], oe_c [2], rs_b [2], rw_b [2];
   logic       prev_en [2], prev_busy [2];
   exp_t       e;

   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (!nRst || done_w[u]) begin
            if (nRst && done_w[u]) begin
               if (q.size() == 0) begin
                  chk($sformatf("unexpected_done_u%0d", u), 1, 0);
               end else begin
                  e = q.pop_front();
                  chk("unit",       u,                   e.unit);
                  chk("latency",    cyc - e.acc,         e.lat);
                  chk("en_pulses",  pulses[u],           e.pulses);
                  chk("en_cycles",  en_tot[u],           e.pulses * 12);
                  chk("db_pass0",   int'(cap0[u]),       int'(e.db0));
                  if (e.pulses == 2) chk("db_pass1", int'(cap1[u]), int'(e.db1));
                  chk("lcd_rs",     int'(rs_c[u]),       int'(e.rs));
                  chk("lcd_rw",     int'(rw_c[u]),       int'(e.rw));
                  chk("lcd_oe",     int'(oe_c[u]),       int'(e.oe));
                  chk("dout",       int'(dout_w[u]),     int'(e.dout));
                  chk("rs_rw_stable", unstable[u],       0);
               end
            end
            pulses[u] = 0; en_tot[u] = 0; unstable[u] = 0;
            prev_en[u] = 1'b0; prev_busy[u] = 1'b0;
         end else begin
            if (busy_w[u] && !prev_busy[u]) begin
               rs_b[u] = rs_w[u];
               rw_b[u] = rw_w[u];
            end else if (busy_w[u] && ((rs_w[u] != rs_b[u]) || (rw_w[u] != rw_b[u]))) begin
               unstable[u]++;
            end
            if (en_w[u]) begin
               en_tot[u]++;
               if (!prev_en[u]) begin
                  if (pulses[u] == 0) begin
                     cap0[u] = db_w[u];
                     rs_c[u] = rs_w[u];
                     rw_c[u] = rw_w[u];
                     oe_c[u] = oe_w[u];
                  end else begin
                     cap1[u] = db_w[u];
                  end
                  pulses[u]++;
               end
            end
            prev_en[u]   = en_w[u];
            prev_busy[u] = busy_w[u];
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic push_exp(input int u, input bit rd, input bit rs_v, input int lat, input int np,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] dout_e);
      exp_t x;
      x.unit = u; x.acc = cyc + 1; x.lat = lat; x.pulses = np;
      x.db0 = d0; x.db1 = d1; x.rs = rs_v; x.rw = rd; x.oe = ~rd; x.dout = dout_e;
      q.push_back(x);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         chk("done_timeout", q.size(), 0);
         q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic release_bus();
      ncs8 = 1'b1; ncs4 = 1'b1; nwr = 1'b1; nrd = 1'b1;
   endtask

   // Host request held two cycles; RS/DIN are then scrambled while the DUT is busy
   task automatic xfer(input int u, input bit rd, input bit rs_v, input logic [7:0] din_v,
                       input int lat, input int np, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] dout_e);
      @(negedge clk);
      if (u == 0) ncs8 = 1'b0; else ncs4 = 1'b0;
      nwr = rd; nrd = ~rd; rs = rs_v; din = din_v;
      push_exp(u, rd, rs_v, lat, np, d0, d1, dout_e);
      repeat (2) @(negedge clk);
      release_bus();
      rs = ~rs_v; din = ~din_v;
      wait_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int rises, bad, n;
      logic prevb;
      nRst = 1'b0; ncs8 = 1'b1; ncs4 = 1'b1; nwr = 1'b1; nrd = 1'b1;
      rs = 1'b0; din = 8'h00; lcd_i8 = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_busy",  int'(busy8), 0);
      chk("rst_done",  int'(done8), 0);
      chk("rst_en",    int'(en8),   0);
      chk("rst_oe",    int'(oe8),   0);
      chk("rst_db",    int'(db8),   0);
      chk("rst_dout",  int'(dout8), 0);
      chk("rst_rs_rw", int'({lrs8, lrw8}), 0);
      chk("rst_busy4", int'(busy4), 0);
      nRst = 1'b1;
      repeat (2) @(negedge clk);

      // 8-bit write, 8-bit read
      xfer(0, 1'b0, 1'b1, 8'h41, 17, 1, 8'h41, 8'h00, 8'h00);
      lcd_i8 = 8'h80;
      xfer(0, 1'b1, 1'b0, 8'h00, 17, 1, 8'h00, 8'h00, 8'h80);
      // 4-bit write and read
      xfer(1, 1'b0, 1'b0, 8'h3C, 33, 2, 8'h30, 8'hC0, 8'h00);
      xfer(1, 1'b1, 1'b1, 8'h00, 33, 2, 8'h00, 8'h00, 8'h69);

      // nCS held low for 100 cycles: only one transfer
      @(negedge clk);
      ncs8 = 1'b0; nwr = 1'b0; rs = 1'b0; din = 8'h12;
      push_exp(0, 1'b0, 1'b0, 17, 1, 8'h12, 8'h00, 8'h80);
      rises = 0; prevb = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (busy8 && !prevb) rises++;
         prevb = busy8;
      end
      chk("one_xfer_per_cs", rises, 1);
      chk("held_cs_done", q.size(), 0);
      ncs8 = 1'b1;
      @(negedge clk);
      ncs8 = 1'b0; din = 8'h34;
      push_exp(0, 1'b0, 1'b0, 17, 1, 8'h34, 8'h00, 8'h80);
      repeat (2) @(negedge clk);
      release_bus();
      wait_idle();

      // Both strobes low: must be ignored
      @(negedge clk);
      ncs8 = 1'b0; nwr = 1'b0; nrd = 1'b0;
      bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (busy8) bad++;
      end
      chk("both_strobes_busy", bad, 0);
      release_bus();
      repeat (3) @(negedge clk);

      // Reset in the 5th EN-high cycle
      @(negedge clk);
      ncs8 = 1'b0; nwr = 1'b0; rs = 1'b1; din = 8'h77;
      n = 0;
      while (!en8 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rst_test_en_seen", int'(en8), 1);
      release_bus();
      repeat (4) @(negedge clk);
      chk("rst_test_en_5th", int'(en8), 1);
      #1 nRst = 1'b0;
      #1;
      chk("async_en_drop",   int'(en8),   0);
      chk("async_busy_drop", int'(busy8), 0);
      chk("async_dout_rst",  int'(dout8), 0);
      repeat (3) @(negedge clk);
      nRst = 1'b1;
      repeat (30) @(negedge clk);
      chk("aborted_dout", int'(dout8), 0);

      // Clean transfer after the abort
      lcd_i8 = 8'h5A;
      xfer(0, 1'b1, 1'b0, 8'h00, 17, 1, 8'h00, 8'h00, 8'h5A);

      chk("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
